// File: rtl/usb_pkg.sv
// usb_pkg -- shared definitions for the USB RXD nibble framer.
//   USB_SYNC_BYTE : default frame sync byte
//   frm_state_e   : framer FSM states, 8-bit encoding with IDLE = 8'h00
//   sel_nibble()  : pick the high or low nibble of a byte
package usb_pkg;

  localparam logic [7:0] USB_SYNC_BYTE = 8'hA5;

  typedef enum logic [7:0] {
    IDLE = 8'h00,
    SYNC = 8'h01,
    LEN  = 8'h02,
    DATA = 8'h03,
    CSUM = 8'h04,
    DONE = 8'h05
  } frm_state_e;

  // lo = 0 selects the high nibble, which always goes out first
  function automatic logic [3:0] sel_nibble(input logic [7:0] b, input logic lo);
    return lo ? b[3:0] : b[7:4];
  endfunction

endpackage

// File: rtl/usb_rxd_framer_if.sv
// usb_rxd_framer_if -- frame request, payload stream and nibble lane of the framer.
//   start/pkt_len        : frame request and payload length
//   s_data/s_valid/s_ready : payload byte handshake
//   pin_rxd/fire_read    : nibble lane and its qualifier
//   busy/done/len_err    : status
// modport slave is the framer side, modport master the requester side.
interface usb_rxd_framer_if;
  logic       start;
  logic [7:0] pkt_len;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] pin_rxd;
  logic       fire_read;
  logic       busy;
  logic       done;
  logic       len_err;

  modport slave (
    input  start, pkt_len, s_data, s_valid,
    output s_ready, pin_rxd, fire_read, busy, done, len_err
  );

  modport master (
    output start, pkt_len, s_data, s_valid,
    input  s_ready, pin_rxd, fire_read, busy, done, len_err
  );
endinterface

// File: rtl/usb_nibble_ser.sv
// usb_nibble_ser -- one-byte holding register that emits its byte as two nibbles.
//   clr       : empty the register (synchronous)
//   load      : capture load_byte, next nibble out is its high nibble
//   adv       : the current nibble is consumed this cycle
//   full      : register holds a byte
//   nibble    : nibble currently presented
//   last      : the low nibble is presented (byte finishes if adv)
// A load in the same cycle as the last nibble is consumed wins, so bytes can
// stream back to back with no empty cycle in between.
module usb_nibble_ser
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       adv,
  output logic       full,
  output logic [3:0] nibble,
  output logic       last
);

  logic [7:0] byte_q, byte_d;
  logic       full_q, full_d;
  logic       lo_q, lo_d;

  // holding register state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q <= 8'h00;
      full_q <= 1'b0;
      lo_q   <= 1'b0;
    end else begin
      byte_q <= byte_d;
      full_q <= full_d;
      lo_q   <= lo_d;
    end
  end

  // load / advance sequencing of the held byte
  always_comb begin
    byte_d = byte_q;
    full_d = full_q;
    lo_d   = lo_q;
    if (clr) begin
      byte_d = 8'h00;
      full_d = 1'b0;
      lo_d   = 1'b0;
    end else if (load) begin
      byte_d = load_byte;
      full_d = 1'b1;
      lo_d   = 1'b0;
    end else if (adv && full_q) begin
      if (lo_q) begin
        full_d = 1'b0;
        lo_d   = 1'b0;
      end else begin
        lo_d = 1'b1;
      end
    end else begin
      lo_d = lo_q;
    end
  end

  assign full   = full_q;
  assign nibble = sel_nibble(byte_q, lo_q);
  assign last   = full_q && lo_q;

endmodule

// File: rtl/usb_rxd_framer.sv
// usb_rxd_framer -- serialises SYNC_BYTE, pkt_len, payload and an XOR checksum
// onto a 4-bit lane, high nibble first, one nibble per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : usb_rxd_framer_if.slave (request, payload handshake, lane, status)
// Every frame byte passes through the single holding register in
// usb_nibble_ser; the FSM decides which byte is loaded next. The lane and all
// status outputs are decoded purely from flops.
module usb_rxd_framer
  import usb_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = USB_SYNC_BYTE,
  parameter int         MAX_LEN   = 255
)
(
  input  logic             clk,
  input  logic             rst_n,
  usb_rxd_framer_if.slave  bus
);

  localparam logic [8:0] MAX_LEN_C = 9'(MAX_LEN);

  frm_state_e state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;     // payload bytes accepted so far
  logic [7:0] csum_q, csum_d;
  logic       len_err_q, len_err_d;

  logic       ser_clr, ser_load, ser_full, ser_last;
  logic [7:0] ser_byte;
  logic [3:0] ser_nibble;
  logic       emit_state_s, fire_s, ready_s, accept_s;

  usb_nibble_ser u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (ser_clr),
    .load      (ser_load),
    .load_byte (ser_byte),
    .adv       (fire_s),
    .full      (ser_full),
    .nibble    (ser_nibble),
    .last      (ser_last)
  );

  // states in which the holding register drives the lane
  always_comb begin
    emit_state_s = 1'b0;
    case (state_q)
      SYNC, LEN, DATA, CSUM: emit_state_s = 1'b1;
      default:               emit_state_s = 1'b0;
    endcase
  end

  // An empty register in DATA is a stall: no nibble, lane held at zero.
  assign fire_s   = emit_state_s && ser_full;
  // Ready while payload is still owed and the register frees up this cycle.
  assign ready_s  = ((state_q == LEN) || (state_q == DATA)) && (cnt_q < len_q) &&
                    (!ser_full || ser_last);
  assign accept_s = bus.s_valid && ready_s;

  // FSM, length, counter, checksum and length-error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= 8'h00;
      cnt_q     <= 8'h00;
      csum_q    <= 8'h00;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      len_err_q <= len_err_d;
    end
  end

  // next-state, byte selection and checksum accumulation
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    len_err_d = 1'b0;
    ser_clr   = 1'b0;
    ser_load  = 1'b0;
    ser_byte  = 8'h00;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if ({1'b0, bus.pkt_len} > MAX_LEN_C) begin
            len_err_d = 1'b1;
          end else begin
            state_d  = SYNC;
            len_d    = bus.pkt_len;
            cnt_d    = 8'h00;
            csum_d   = bus.pkt_len;   // cleared, then XORed with pkt_len
            ser_load = 1'b1;
            ser_byte = SYNC_BYTE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SYNC: begin
        if (ser_last) begin
          state_d  = LEN;
          ser_load = 1'b1;
          ser_byte = len_q;
        end else begin
          state_d = SYNC;
        end
      end
      LEN: begin
        if (ser_last) begin
          if (len_q == 8'h00) begin
            state_d  = CSUM;
            ser_load = 1'b1;
            ser_byte = csum_q;
          end else begin
            state_d = DATA;
            if (accept_s) begin
              ser_load = 1'b1;
              ser_byte = bus.s_data;
              cnt_d    = cnt_q + 8'd1;
              csum_d   = csum_q ^ bus.s_data;
            end else begin
              ser_load = 1'b0;
            end
          end
        end else begin
          state_d = LEN;
        end
      end
      DATA: begin
        // all payload accepted and its last nibble leaving: csum already complete
        if (ser_last && (cnt_q == len_q)) begin
          state_d  = CSUM;
          ser_load = 1'b1;
          ser_byte = csum_q;
        end else if (accept_s) begin
          ser_load = 1'b1;
          ser_byte = bus.s_data;
          cnt_d    = cnt_q + 8'd1;
          csum_d   = csum_q ^ bus.s_data;
        end else begin
          state_d = DATA;
        end
      end
      CSUM: begin
        if (ser_last) begin
          state_d = DONE;
        end else begin
          state_d = CSUM;
        end
      end
      DONE: begin
        state_d = IDLE;
        ser_clr = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ser_clr = 1'b1;
      end
    endcase
  end

  assign bus.pin_rxd   = fire_s ? ser_nibble : 4'h0;
  assign bus.fire_read = fire_s;
  assign bus.s_ready   = ready_s;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.len_err   = len_err_q;

endmodule

// File: tb/tb_usb_rxd_framer.sv
// tb_usb_rxd_framer -- self-checking bench for usb_rxd_framer.
// The expected nibble stream of each frame is built from the frame rules:
// bytes {A5, len, payload..., len ^ XOR(payload)}, each split high nibble first.
module tb_usb_rxd_framer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [7:0] pay [256];

  usb_rxd_framer_if bus ();
  usb_rxd_framer_if bus16 ();

  usb_rxd_framer #(.SYNC_BYTE(8'hA5), .MAX_LEN(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  usb_rxd_framer #(.SYNC_BYTE(8'hA5), .MAX_LEN(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         len;
    int         fill;      // 0: b0/b1, 1: incrementing bytes
    logic [7:0] b0;
    logic [7:0] b1;
    int         hold;      // cycles s_valid is withheld after LEN
    int         exp_cycles;
    logic [7:0] exp_csum;
  } vec_t;

  vec_t vecs [6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one frame on the default instance and compares its lane to the model.
  task automatic run_frame(input int len, input int stall_pct, input int hold, input bit junk,
                           output int cycles, output logic [7:0] csum_obs);
    logic [3:0] got [$];
    logic [3:0] exp_n [$];
    logic [7:0] bytes_q [$];
    logic [7:0] cs;
    int idx, cyc, done_cyc, last_fire;
    cs = len[7:0];
    bytes_q.push_back(8'hA5);
    bytes_q.push_back(len[7:0]);
    for (int i = 0; i < len; i++) begin
      bytes_q.push_back(pay[i]);
      cs = cs ^ pay[i];
    end
    bytes_q.push_back(cs);
    foreach (bytes_q[i]) begin
      exp_n.push_back(bytes_q[i][7:4]);
      exp_n.push_back(bytes_q[i][3:0]);
    end
    chk("idle_before_start", 32'(bus.busy), 32'h0);
    bus.pkt_len = len[7:0];
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    idx = 0; cyc = 1; done_cyc = 0; last_fire = 0;
    while (cyc <= 2000) begin
      if (cyc == 1) chk("first_nibble_latency", 32'(bus.fire_read), 32'h1);
      if (bus.fire_read) begin
        got.push_back(bus.pin_rxd);
        last_fire = cyc;
      end else begin
        chk("pin_zero_without_fire", 32'(bus.pin_rxd), 32'h0);
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (idx >= len) chk("ready_after_last_byte", 32'(bus.s_ready), 32'h0);
      if (idx < len) begin
        bus.s_valid = (cyc >= 4 + hold) && ($urandom_range(0, 99) >= stall_pct);
        bus.s_data  = pay[idx];
      end else begin
        bus.s_valid = junk && ($urandom_range(0, 1) == 1);
        bus.s_data  = 8'($urandom);
      end
      bus.start   = junk && ($urandom_range(0, 9) == 0);
      bus.pkt_len = junk ? 8'($urandom) : len[7:0];
      if (bus.s_valid && bus.s_ready && (idx < len)) idx++;
      tick();
      cyc++;
    end
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    cycles = done_cyc;
    chk("done_seen", 32'(done_cyc != 0), 32'h1);
    chk("bytes_accepted", 32'(idx), 32'(len));
    chk("fire_count", 32'(got.size()), 32'(exp_n.size()));
    for (int i = 0; i < exp_n.size() && i < got.size(); i++)
      chk("nibble", 32'(got[i]), 32'(exp_n[i]));
    chk("done_after_last_nibble", 32'(last_fire), 32'(done_cyc - 1));
    if (stall_pct == 0 && hold == 0) chk("gapless_length", 32'(done_cyc), 32'(2 * len + 7));
    csum_obs = (got.size() >= 2) ? {got[got.size() - 2], got[got.size() - 1]} : 8'h00;
    if (done_cyc != 0) begin
      tick();
      chk("done_one_cycle", 32'(bus.done), 32'h0);
      chk("idle_after_done", 32'(bus.busy), 32'h0);
    end
  endtask

  initial begin
    int         cyc;
    int         k;
    bit         seen;
    logic [7:0] cs;
    errors = 0;
    checks = 0;
    vecs[0] = '{len: 2,   fill: 0, b0: 8'h12, b1: 8'h34, hold: 0, exp_cycles: 11,  exp_csum: 8'h24};
    vecs[1] = '{len: 0,   fill: 0, b0: 8'h00, b1: 8'h00, hold: 0, exp_cycles: 7,   exp_csum: 8'h00};
    vecs[2] = '{len: 1,   fill: 0, b0: 8'hAB, b1: 8'h00, hold: 0, exp_cycles: 9,   exp_csum: 8'hAA};
    vecs[3] = '{len: 2,   fill: 0, b0: 8'hFF, b1: 8'h00, hold: 0, exp_cycles: 11,  exp_csum: 8'hFD};
    vecs[4] = '{len: 1,   fill: 0, b0: 8'h5C, b1: 8'h00, hold: 5, exp_cycles: 14,  exp_csum: 8'h5D};
    vecs[5] = '{len: 255, fill: 1, b0: 8'h00, b1: 8'h00, hold: 0, exp_cycles: 517, exp_csum: 8'h00};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.pkt_len = 8'h00; bus.s_data = 8'h00; bus.s_valid = 1'b0;
    bus16.start = 1'b0; bus16.pkt_len = 8'h00; bus16.s_data = 8'h00; bus16.s_valid = 1'b0;
    tick();
    tick();
    chk("reset_outputs", 32'({bus.pin_rxd, bus.fire_read, bus.s_ready, bus.busy, bus.done, bus.len_err}), 32'h0);
    chk("reset_outputs16", 32'({bus16.pin_rxd, bus16.fire_read, bus16.busy, bus16.len_err}), 32'h0);
    rst_n = 1'b1;
    tick();

    // table-driven frames
    for (int v = 0; v < 6; v++) begin
      logic [7:0] csum_obs;
      for (int i = 0; i < 256; i++) pay[i] = (vecs[v].fill == 1) ? 8'(i) : 8'h00;
      if (vecs[v].fill == 0) begin
        pay[0] = vecs[v].b0;
        pay[1] = vecs[v].b1;
      end
      run_frame(vecs[v].len, 0, vecs[v].hold, 1'b0, cyc, csum_obs);
      chk("vec_cycles", 32'(cyc), 32'(vecs[v].exp_cycles));
      chk("vec_csum", 32'(csum_obs), 32'(vecs[v].exp_csum));
      tick();
    end

    // length above MAX_LEN is rejected with a single len_err pulse
    bus16.pkt_len = 8'd17;
    bus16.start   = 1'b1;
    tick();
    bus16.start = 1'b0;
    chk("len_err_pulse", 32'(bus16.len_err), 32'h1);
    chk("len_err_not_busy", 32'(bus16.busy), 32'h0);
    tick();
    chk("len_err_one_cycle", 32'(bus16.len_err), 32'h0);
    chk("len_err_still_idle", 32'(bus16.busy), 32'h0);
    // exactly MAX_LEN is accepted
    bus16.pkt_len = 8'd16;
    bus16.start   = 1'b1;
    tick();
    bus16.start = 1'b0;
    chk("max_len_accepted", 32'(bus16.busy), 32'h1);
    chk("max_len_no_err", 32'(bus16.len_err), 32'h0);
    bus16.s_valid = 1'b1;
    bus16.s_data  = 8'h3C;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus16.done) seen = 1'b1;
      else tick();
    end
    bus16.s_valid = 1'b0;
    chk("max_len_done", 32'(seen), 32'h1);
    tick();

    // reset in the middle of DATA aborts the frame
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    bus.pkt_len = 8'd4;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      bus.s_valid = (k < 4);
      bus.s_data  = pay[k];
      if (bus.s_valid && bus.s_ready) k++;
      tick();
    end
    chk("busy_mid_data", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({bus.pin_rxd, bus.fire_read, bus.s_ready, bus.busy, bus.done, bus.len_err}), 32'h0);
    tick();
    chk("abort_no_done", 32'({bus.done, bus.fire_read, bus.busy}), 32'h0);
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_after_abort", 32'(bus.busy), 32'h0);
    begin
      logic [7:0] csum_obs;
      pay[0] = 8'h0F; pay[1] = 8'hF0; pay[2] = 8'h81;
      run_frame(3, 0, 0, 1'b0, cyc, csum_obs);
      cs = 8'h03 ^ 8'h0F ^ 8'hF0 ^ 8'h81;
      chk("clean_frame_csum", 32'(csum_obs), 32'(cs));
      tick();
    end

    // random frames with stalls, extra s_valid and start pulses while busy
    for (int f = 0; f < 15; f++) begin
      logic [7:0] csum_obs;
      int len;
      len = $urandom_range(0, 24);
      for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
      run_frame(len, (f % 3 == 0) ? 0 : $urandom_range(0, 60), 0, (f % 3 != 0), cyc, csum_obs);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_rxd_framer.md
USB_RXD_FRAMER -- requirements
Module: usb_rxd_framer

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, giving the frame sync byte.
REQ-002 The block SHALL have parameter MAX_LEN, default 255, giving the largest accepted payload length.
REQ-003 Port clk: input, 1 bit; the single clock.
REQ-004 Port rst_n: input, 1 bit; asynchronous, active-low reset.
REQ-005 Port start: input, 1 bit; one-cycle request to send a frame, honoured only in IDLE.
REQ-006 Port pkt_len: input, 8 bits; payload byte count, sampled when start is accepted.
REQ-007 Port s_data: input, 8 bits; payload byte.
REQ-008 Port s_valid: input, 1 bit; s_data is valid.
REQ-009 Port s_ready: output, 1 bit; block accepts s_data this cycle.
REQ-010 Port pin_rxd: output, 4 bits; nibble lane towards the differential output buffers.
REQ-011 Port fire_read: output, 1 bit; pin_rxd carries a valid nibble this cycle.
REQ-012 Port busy: output, 1 bit; a frame is in progress (state not IDLE).
REQ-013 Port done: output, 1 bit; one-cycle pulse after the last checksum nibble.
REQ-014 Port len_err: output, 1 bit; one-cycle pulse when start is rejected because pkt_len exceeds MAX_LEN.

Function
REQ-015 The FSM SHALL have the states IDLE, SYNC, LEN, DATA, CSUM and DONE.
REQ-016 Frame order SHALL be: SYNC_BYTE, pkt_len, payload bytes, checksum; every byte is sent high nibble first, one nibble per cycle.
REQ-017 The checksum SHALL be the 8-bit XOR of pkt_len and all payload bytes; it is cleared when start is accepted.
REQ-018 fire_read SHALL be 1 exactly in the cycles in which pin_rxd carries a frame nibble; in all other cycles pin_rxd SHALL be 4'h0.
REQ-019 In IDLE, start=1 with pkt_len<=MAX_LEN SHALL move the FSM to SYNC on the next edge; the first nibble appears in the cycle after start (latency 1).
REQ-020 When start=1 and pkt_len>MAX_LEN, the FSM SHALL stay in IDLE and pulse len_err.
REQ-021 The FSM SHALL go SYNC -> LEN after 2 nibbles.
REQ-022 The FSM SHALL go LEN -> DATA after 2 nibbles, or LEN -> CSUM if pkt_len==0.
REQ-023 The FSM SHALL go DATA -> CSUM after pkt_len bytes.
REQ-024 The FSM SHALL go CSUM -> DONE after 2 nibbles, then DONE -> IDLE unconditionally.
REQ-025 A one-byte holding register SHALL be provided; s_ready=1 only in LEN/DATA while the register is empty or its low nibble is being emitted this cycle.
REQ-026 A byte SHALL be transferred on s_valid&&s_ready; with s_valid held high, payload SHALL stream without gaps.
REQ-027 If the holding register is empty during DATA, the block SHALL stall: fire_read=0, pin_rxd=0, nibble position held; it resumes on the next accepted byte.
REQ-028 s_ready SHALL be 0 once pkt_len bytes have been accepted; extra s_valid SHALL be ignored.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 The payload byte counter SHALL be 8 bits wide; pkt_len=255 SHALL complete without wrap.

Reset
REQ-031 While rst_n=0, the state SHALL be IDLE and the checksum, counters and holding register SHALL be cleared.
REQ-032 While rst_n=0, pin_rxd=0, fire_read=0, s_ready=0, busy=0, done=0 and len_err=0.
REQ-033 Reset mid-frame SHALL abort the frame immediately; done SHALL not pulse.

Structure
REQ-034 The FSM state encodings (8-bit, IDLE=8'h00) and SYNC_BYTE SHALL be held in the shared package usb_pkg.
REQ-035 Nibble sequencing SHALL be one sub-module, usb_nibble_ser (byte in, high/low nibble out, last-nibble flag); the FSM and checksum SHALL live in the top.

Verification
REQ-036 Scenario: start, pkt_len=2, bytes 8'h12, 8'h34 with s_valid held -> nibbles A,5,0,2,1,2,3,4,2,4 on 10 consecutive fire_read cycles, then done.
REQ-037 Scenario: pkt_len=0 -> nibbles A,5,0,0,0,0; s_ready never asserted.
REQ-038 Scenario: pkt_len=1, s_valid delayed 5 cycles in DATA -> fire_read low for the stall with pin_rxd=0, then 4'h?,4'h? byte and correct checksum.
REQ-039 Scenario: MAX_LEN=16, pkt_len=17 -> len_err pulse, busy stays 0.
REQ-040 Scenario: rst_n low during DATA of a pkt_len=4 frame -> all outputs 0 next cycle, no done; a new start then yields a clean frame.
REQ-041 Scenario: pkt_len=255 with incrementing bytes -> 516 fire_read cycles and checksum = XOR of 8'hFF and bytes 0..254.
